systolic_seq_ctrl: RTL

- Sequencer for the 4x4 output-stationary systolic multiply array.
- Holds operand matrices A (NxN) and B (NxN), loaded through a simple write port.
- On start it clears the array accumulators (optional) and drives the skewed west/north operand wavefronts. It pulses done once the last product has been accumulated in the far-corner PE.
- Sits between the host/DMA load logic and the array; the array's synchronous active-high reset is driven from array_clr.

---
 rtl/systolic_seq_ctrl_pkg.sv | 33 +++
 rtl/systolic_seq_ctrl_if.sv | 38 +++
 rtl/systolic_operand_store.sv | 45 ++++
 rtl/systolic_seq_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
// Imported by the interface, the operand store and the top.
package systolic_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DONE
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (feed_len(n) > 1) ? $clog2(feed_len(n)) : 1;
    endfunction

    localparam int N_DEF    = 4;
    localparam int DW_DEF   = 32;
    localparam int FEED_LEN = feed_len(N_DEF);
    localparam int IDX_W    = idx_w(N_DEF);
    localparam int CNT_W    = cnt_w(N_DEF);

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host-side load/start port and array-side operand buses
// of the systolic sequencer, bundled with master/slave views.
interface systolic_seq_ctrl_if #(
    parameter int DW = 32,
    parameter int N  = 4
);
    import systolic_seq_ctrl_pkg::*;

    localparam int IW = idx_w(N);

    logic              wr_en;
    logic              wr_sel;
    logic [2*IW-1:0]   wr_addr;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic              accumulate;
    logic              busy;
    logic              done;
    logic              wr_err;
    logic              array_clr;
    logic [N*DW-1:0]   west;
    logic [N*DW-1:0]   north;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data,
        output start, accumulate,
        input  busy, done, wr_err, array_clr,
        input  west, north
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data,
        input  start, accumulate,
        output busy, done, wr_err, array_clr,
        output west, north
    );

endinterface

// File: rtl/systolic_operand_store.sv
// NxN operand register file: one write port, N skew-indexed read
// ports. A same-cycle write is forwarded to matching read ports.
module systolic_operand_store
    import systolic_seq_ctrl_pkg::*;
#(
    parameter  int DW = 32,
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IW-1:0]   wr_row,
    input  logic [IW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic [N*IW-1:0] rd_row,
    input  logic [N*IW-1:0] rd_col,
    output logic [N*DW-1:0] rd_data
);

    logic [DW-1:0] mem [N][N];

    // Operand write; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Read ports with write-through so a load issued alongside
    // start is seen by the very first wavefront.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < N; p++) begin
            if (we &&
                rd_row[p*IW +: IW] == wr_row &&
                rd_col[p*IW +: IW] == wr_col) begin
                rd_data[p*DW +: DW] = wr_data;
            end else begin
                rd_data[p*DW +: DW] =
                    mem[rd_row[p*IW +: IW]][rd_col[p*IW +: IW]];
            end
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the NxN output-stationary systolic array: holds
// A and B, clears the array and drives skewed operand wavefronts.
module systolic_seq_ctrl
    import systolic_seq_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int N  = 4
) (
    input  logic clk,
    input  logic rst,
    systolic_seq_ctrl_if.slave bus
);

    localparam int IW   = idx_w(N);
    localparam int CW   = cnt_w(N);
    localparam int LAST = feed_len(N) - 1;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   t;
    logic [CW-1:0]   t_nxt;
    logic            idle;
    logic            a_we;
    logic            b_we;
    logic [IW-1:0]   wr_row;
    logic [IW-1:0]   wr_col;
    logic [N*IW-1:0] a_row;
    logic [N*IW-1:0] a_col;
    logic [N*IW-1:0] b_row;
    logic [N*IW-1:0] b_col;
    logic [N-1:0]    a_ok;
    logic [N-1:0]    b_ok;
    logic [N*DW-1:0] a_rd;
    logic [N*DW-1:0] b_rd;
    logic [N*DW-1:0] west_nxt;
    logic [N*DW-1:0] north_nxt;
    logic [N*DW-1:0] west_q;
    logic [N*DW-1:0] north_q;
    logic            clr_q;
    logic            err_q;

    assign idle   = (state == S_IDLE);
    assign wr_row = bus.wr_addr[2*IW-1:IW];
    assign wr_col = bus.wr_addr[IW-1:0];
    assign a_we   = bus.wr_en && idle && (bus.wr_sel == SEL_A);
    assign b_we   = bus.wr_en && idle && (bus.wr_sel == SEL_B);

    systolic_operand_store #(.DW(DW), .N(N)) u_store_a (
        .clk     (clk),
        .we      (a_we),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (bus.wr_data),
        .rd_row  (a_row),
        .rd_col  (a_col),
        .rd_data (a_rd)
    );

    systolic_operand_store #(.DW(DW), .N(N)) u_store_b (
        .clk     (clk),
        .we      (b_we),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (bus.wr_data),
        .rd_row  (b_row),
        .rd_col  (b_col),
        .rd_data (b_rd)
    );

    // Next state and feed counter.
    always_comb begin
        state_nxt = state;
        t_nxt     = '0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = bus.accumulate ? S_FEED : S_CLEAR;
                end
            end
            S_CLEAR: state_nxt = S_FEED;
            S_FEED: begin
                if (t == CW'(LAST)) begin
                    state_nxt = S_DONE;
                end else begin
                    t_nxt = t + CW'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Skewed element selection for the cycle being entered; the
    // difference is signed so negative offsets never alias.
    always_comb begin
        int d;
        a_row     = '0;
        a_col     = '0;
        b_row     = '0;
        b_col     = '0;
        a_ok      = '0;
        b_ok      = '0;
        west_nxt  = '0;
        north_nxt = '0;
        for (int k = 0; k < N; k++) begin
            d = int'(t_nxt) - k;
            a_ok[k] = (d >= 0) && (d < N);
            b_ok[k] = a_ok[k];
            a_row[k*IW +: IW] = IW'(k);
            a_col[k*IW +: IW] = d[IW-1:0];
            b_row[k*IW +: IW] = d[IW-1:0];
            b_col[k*IW +: IW] = IW'(k);
            if (state_nxt == S_FEED && a_ok[k]) begin
                west_nxt[k*DW +: DW] = a_rd[k*DW +: DW];
            end
            if (state_nxt == S_FEED && b_ok[k]) begin
                north_nxt[k*DW +: DW] = b_rd[k*DW +: DW];
            end
        end
    end

    // State register and feed counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            t     <= '0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
        end
    end

    // Registered array-facing outputs; array held clear in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            west_q  <= '0;
            north_q <= '0;
            clr_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            west_q  <= west_nxt;
            north_q <= north_nxt;
            clr_q   <= (state_nxt == S_CLEAR);
            err_q   <= bus.wr_en && !idle;
        end
    end

    assign bus.busy      = !idle;
    assign bus.done      = (state == S_DONE);
    assign bus.wr_err    = err_q;
    assign bus.array_clr = clr_q;
    assign bus.west      = west_q;
    assign bus.north     = north_q;

endmodule
